disp_scan: RTL and testbench
============================

DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of digit positions, range 1..8.
REQ-002 SHALL have parameter DIV, default 50000: clock cycles per digit slot, minimum 4.
REQ-003 SHALL have parameter BLANK_CYC, default 16: dead-time cycles at the start of each slot, range 1..DIV-2.
REQ-004 SHALL have parameter ACT_LOW, default 1: when 1, seg_d and seg_w are inverted at the pins.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; everything is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port data, input, 4*DIGITS bits: hex nibble per digit; nibble i is data[4i+3:4i]; digit 0 is rightmost.
REQ-008 SHALL have port dp, input, DIGITS bits: decimal point per digit.
REQ-009 SHALL have port num, input, 4 bits: number of active digits, counted from digit 0.
REQ-010 SHALL have port lz_blank, input, 1 bit: enables leading-zero blanking.
REQ-011 SHALL have port load, input, 1 bit: one-cycle strobe that captures data, dp and num.
REQ-012 SHALL have port seg_d, output, 8 bits: {dp,g,f,e,d,c,b,a} segment data.
REQ-013 SHALL have port seg_w, output, DIGITS bits: one-hot digit select.
REQ-014 SHALL have port frame, output, 1 bit: one-cycle pulse at the start of each scan frame.

Function
REQ-015 On load, data/dp/num SHALL go into pending registers; pending SHALL transfer to active registers only at a frame boundary (tick_cnt==DIV-1 and idx==num_a-1, or num_a==0 and tick_cnt==DIV-1).
REQ-016 If load coincides with a frame-boundary cycle, the values presented that cycle SHALL go directly into the active registers.
REQ-017 Active num (num_a) SHALL be clamped to DIGITS when num>DIGITS.
REQ-018 tick_cnt SHALL count 0..DIV-1 and wrap; on wrap, idx SHALL advance, and SHALL return to 0 after num_a-1.
REQ-019 During a slot, seg_w SHALL be all-inactive while tick_cnt<BLANK_CYC, then one-hot on bit idx for the rest of the slot.
REQ-020 If num_a==0, seg_w SHALL stay all-inactive, idx SHALL stay 0, and frame SHALL still pulse once per DIV cycles.
REQ-021 Hex decode SHALL give gfedcba of 0:0x3F, 1:0x06, 2:0x5B, 3:0x4F, 4:0x66, 5:0x6D, 6:0x7D, 7:0x07, 8:0x7F, 9:0x6F, A:0x77, b:0x7C, C:0x39, d:0x5E, E:0x79, F:0x71 (active-high form).
REQ-022 Leading-zero blanking: when lz_blank=1, digits from num_a-1 downward SHALL show g..a all off while their nibble is 0, until the first nonzero digit.
REQ-023 Digit 0 SHALL never be blanked by leading-zero blanking.
REQ-024 The dp bit SHALL remain driven on any digit blanked by leading-zero blanking.
REQ-025 seg_d, seg_w and frame SHALL be registered and reflect the previous cycle's idx/tick_cnt (1-cycle latency).
REQ-026 frame SHALL be 1 for exactly one cycle after the cycle where idx==0 and tick_cnt==0.
REQ-027 Polarity inversion (ACT_LOW) SHALL be applied at the output registers only.

Reset
REQ-028 While rst=1, tick_cnt, idx, and all pending and active registers SHALL clear to 0.
REQ-029 The cycle after any rst=1 edge, seg_d and seg_w SHALL be all-inactive (0xFF and all-ones when ACT_LOW=1) and frame SHALL be 0.
REQ-030 After reset, the display SHALL stay dark until a load is applied and reaches a frame boundary.
REQ-031 Reset asserted mid-slot SHALL take priority over load and over the counters in the same cycle.

Verification (DIGITS=4, DIV=8, BLANK_CYC=2, ACT_LOW=0)
REQ-032 Reset, then load data=0x1234, num=4 -> from the next frame, each slot shows seg_w 0000 for 2 cycles, then 6 cycles of digit 0 0001/0x66, digit 1 0010/0x4F, digit 2 0100/0x5B, digit 3 1000/0x06; frame period is 32 cycles.
REQ-033 data=0x0050, num=4, lz_blank=1 -> digits 3 and 2 show seg_d=0x00, digit 1 shows 0x6D, digit 0 shows 0x3F; with lz_blank=0, digits 3 and 2 show 0x3F.
REQ-034 data=0x0000, dp=0100, lz_blank=1 -> digit 2 shows seg_d=0x80, digit 0 shows 0x3F.
REQ-035 Load mid-frame -> displayed digits do not change until the boundary; load on the boundary cycle -> new value shown in the very next slot; num=9 -> scan covers 4 digits.
REQ-036 num=0 -> seg_w stays 0000 and frame pulses every 8 cycles; rst pulse mid-slot -> outputs inactive the next cycle and display dark until a new load is applied.

Source files
------------

// File: rtl/disp_scan.sv
// Multiplexed 7-segment scanner: double-buffered digit data, per-slot dead time,
// hex decode with leading-zero blanking, registered (optionally inverted) pins.
module disp_scan #(
  parameter int DIGITS    = 4,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 16,
  parameter bit ACT_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [3:0]            num,
  input  logic                  lz_blank,
  input  logic                  load,
  output logic [7:0]            seg_d,
  output logic [DIGITS-1:0]     seg_w,
  output logic                  frame
);

  localparam int TW = $clog2(DIV);
  localparam logic [TW-1:0]     T_LAST  = TW'(DIV - 1);
  localparam logic [TW-1:0]     T_BLANK = TW'(BLANK_CYC);
  localparam logic [3:0]        DIG4    = 4'(DIGITS);
  localparam logic [7:0]        OFF_D   = {8{ACT_LOW}};
  localparam logic [DIGITS-1:0] OFF_W   = {DIGITS{ACT_LOW}};

  logic [TW-1:0]         tick_cnt;
  logic [3:0]            idx;
  logic [4*DIGITS-1:0]   data_p, data_a;
  logic [DIGITS-1:0]     dp_p, dp_a;
  logic [3:0]            num_p, num_a, num_c;
  logic                  slot_end, frame_end;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign num_c     = (num > DIG4) ? DIG4 : num;
  assign slot_end  = (tick_cnt == T_LAST);
  assign frame_end = slot_end && ((num_a == 4'd0) || (idx == num_a - 4'd1));

  // Scan counters and the pending/active double buffer; the active set only
  // changes on a frame boundary so a frame never mixes old and new digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      idx      <= '0;
      data_p   <= '0;
      dp_p     <= '0;
      num_p    <= '0;
      data_a   <= '0;
      dp_a     <= '0;
      num_a    <= '0;
    end else begin
      if (slot_end) begin
        tick_cnt <= '0;
        idx      <= frame_end ? 4'd0 : idx + 4'd1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      if (load) begin
        data_p <= data;
        dp_p   <= dp;
        num_p  <= num_c;
      end
      if (frame_end && load) begin
        data_a <= data;
        dp_a   <= dp;
        num_a  <= num_c;
      end else if (frame_end) begin
        data_a <= data_p;
        dp_a   <= dp_p;
        num_a  <= num_p;
      end
    end
  end

  logic [DIGITS-1:0] lz_vec, sel;
  logic [3:0]        cur_nib;
  logic              cur_dp, cur_lz, run, show;
  logic [7:0]        seg_n;
  logic [DIGITS-1:0] w_n;

  always_comb begin
    lz_vec  = '0;
    sel     = '0;
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    run     = 1'b1;
    // Walk down from the most significant active digit while nibbles stay zero.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (i[3:0] < num_a) begin
        run       = run && (data_a[4*i +: 4] == 4'h0);
        lz_vec[i] = lz_blank && run && (i != 0);
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == i[3:0]) begin
        cur_nib = data_a[4*i +: 4];
        cur_dp  = dp_a[i];
        cur_lz  = lz_vec[i];
        sel[i]  = 1'b1;
      end
    end
    show  = (num_a != 4'd0) && (tick_cnt >= T_BLANK);
    seg_n = show ? {cur_dp, cur_lz ? 7'h00 : hex7(cur_nib)} : 8'h00;
    w_n   = show ? sel : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_d <= OFF_D;
      seg_w <= OFF_W;
      frame <= 1'b0;
    end else begin
      seg_d <= ACT_LOW ? ~seg_n : seg_n;
      seg_w <= ACT_LOW ? ~w_n : w_n;
      frame <= (idx == 4'd0) && (tick_cnt == '0);
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Randomised bench for disp_scan against a cycle-level behavioural model of the
// scan timeline, plus directed checks on the example digit patterns.
module tb_disp_scan;
  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  num = '0;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  seg_d;
  logic [3:0]  seg_w;
  logic        frame;

  always #5 clk = ~clk;

  disp_scan #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYC(BLANK), .ACT_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .num(num),
    .lz_blank(lz_blank), .load(load), .seg_d(seg_d), .seg_w(seg_w), .frame(frame)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          t = 0, dg = 0, act_n = 0, pend_n = 0;
  logic [15:0] act_data = '0, pend_data = '0;
  logic [3:0]  act_dp = '0, pend_dp = '0;
  logic [7:0]  exp_segd = '0;
  logic [3:0]  exp_segw = '0;
  logic        exp_frame = 1'b0, exp_dchk = 1'b0, started = 1'b0;

  function automatic logic [7:0] glyph_for(input int d);
    logic [3:0] nib;
    bit all_zero;
    nib = act_data[4*d +: 4];
    all_zero = 1'b1;
    for (int j = d; j < act_n; j++)
      if (act_data[4*j +: 4] != 4'h0) all_zero = 1'b0;
    if (lz_blank && d != 0 && all_zero) return {act_dp[d], 7'h00};
    return {act_dp[d], GLYPH[nib]};
  endfunction

  always @(posedge clk) begin
    bit bnd;
    cyc++;
    started = 1'b1;
    if (rst) begin
      t = 0; dg = 0; act_n = 0; pend_n = 0;
      act_data = '0; pend_data = '0; act_dp = '0; pend_dp = '0;
      exp_segd = 8'h00; exp_segw = 4'h0; exp_frame = 1'b0; exp_dchk = 1'b1;
    end else begin
      exp_frame = (dg == 0 && t == 0);
      exp_dchk  = (act_n != 0 && t >= BLANK);
      exp_segw  = exp_dchk ? 4'(1 << dg) : 4'h0;
      exp_segd  = exp_dchk ? glyph_for(dg) : 8'h00;
      bnd = (t == DIV - 1) && (act_n == 0 || dg == act_n - 1);
      if (load) begin
        pend_data = data; pend_dp = dp;
        pend_n = (int'(num) > DIGITS) ? DIGITS : int'(num);
      end
      if (bnd) begin
        act_data = pend_data; act_dp = pend_dp; act_n = pend_n;
      end
      t++;
      if (t == DIV) begin
        t = 0;
        dg = bnd ? 0 : dg + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("seg_w", 32'(seg_w), 32'(exp_segw));
      check("frame", 32'(frame), 32'(exp_frame));
      if (exp_dchk) check("seg_d", 32'(seg_d), 32'(exp_segd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] n,
                         input logic lz);
    data = d; dp = p; num = n; lz_blank = lz; load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  task automatic wait_frame(output int c);
    c = -1;
    for (int k = 0; k < 200; k++) begin
      tick(1);
      if (frame === 1'b1) begin c = cyc; break; end
    end
    if (c < 0) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_boundary();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (t == DIV - 1 && (act_n == 0 || dg == act_n - 1)) begin found = 1'b1; break; end
      tick(1);
    end
    if (!found) check("bnd_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int c1, c2;
    tick(3);
    rst = 1'b0;
    tick(20);                                   // dark until a load lands

    do_load(16'h1234, 4'h0, 4'd4, 1'b0);
    tick(20);
    wait_frame(c1);
    tick(2);  check("d0_w", 32'(seg_w), 32'h1); check("d0_seg", 32'(seg_d), 32'h66);
    tick(8);  check("d1_w", 32'(seg_w), 32'h2); check("d1_seg", 32'(seg_d), 32'h4F);
    tick(8);  check("d2_w", 32'(seg_w), 32'h4); check("d2_seg", 32'(seg_d), 32'h5B);
    tick(8);  check("d3_w", 32'(seg_w), 32'h8); check("d3_seg", 32'(seg_d), 32'h06);
    wait_frame(c2);
    check("frame_period", 32'(c2 - c1), 32'd32);

    do_load(16'h0050, 4'h0, 4'd4, 1'b1);
    tick(70);
    lz_blank = 1'b0;
    tick(40);
    do_load(16'h0000, 4'b0100, 4'd4, 1'b1);
    tick(70);
    do_load(16'hABCD, 4'b1010, 4'd9, 1'b0);     // clamped to 4 digits
    tick(70);

    wait_boundary();
    do_load(16'h9876, 4'b0001, 4'd3, 1'b1);     // lands directly on the boundary
    tick(40);
    tick(13);
    do_load(16'h0F00, 4'h0, 4'd2, 1'b1);        // mid-frame load
    tick(40);

    do_load(16'h5555, 4'h0, 4'd0, 1'b0);
    tick(20);
    wait_frame(c1);
    wait_frame(c2);
    check("num0_period", 32'(c2 - c1), 32'd8);

    do_load(16'h4321, 4'h3, 4'd4, 1'b0);
    tick(45);
    rst = 1'b1; load = 1'b1; data = 16'hFFFF;   // reset beats a coincident load
    tick(1);
    rst = 1'b0; load = 1'b0;
    check("rst_segw", 32'(seg_w), 32'h0);
    check("rst_segd", 32'(seg_d), 32'h00);
    check("rst_frame", 32'(frame), 32'h0);
    tick(30);

    for (int it = 0; it < 60; it++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 2) == 0) d[15:8] = 8'h00;
      if ($urandom_range(0, 3) == 0) d = 16'(d & 16'h000F);
      if ($urandom_range(0, 5) == 0) wait_boundary();
      do_load(d, 4'($urandom), 4'($urandom_range(0, 9)), 1'($urandom));
      tick($urandom_range(1, 60));
      if ($urandom_range(0, 11) == 0) begin
        rst = 1'b1; tick(1); rst = 1'b0;
        tick($urandom_range(1, 20));
      end
    end
    tick(40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
